// File: rtl/vwb_scheduler.sv
// VRF write-back scheduler: round-robin arbitration between ALU and load results, then LANES-wide beat streaming.
// Optional macro VWB_STALL_CNT_EN adds a saturating 32-bit stall counter output.
module vwb_scheduler #(
  parameter  int VL     = 8,
  parameter  int SEW    = 32,
  parameter  int LANES  = 2,
  localparam int BEATS  = VL / LANES,
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int LW     = LANES * SEW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [4:0]        alu_vd,
  input  logic [VL*SEW-1:0] alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [4:0]        ld_vd,
  input  logic [VL*SEW-1:0] ld_data,
  output logic              vrf_we,
  output logic [4:0]        vrf_vd,
  output logic [BEAT_W-1:0] vrf_beat,
  output logic [LW-1:0]     vrf_wdata,
  output logic              wb_last,
  output logic              busy,
  output logic [4:0]        busy_vd
`ifdef VWB_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                      state;
  logic                        prio_ld;  // 1: load wins a tie next time
  logic [BEATS-1:0][LW-1:0]    cap_data;
  logic [BEATS-1:0][LW-1:0]    in_data;
  logic [4:0]                  in_vd;
  logic [BEAT_W-1:0]           next_beat;
  logic                        last_beat, accept, grant_alu, grant_ld, xfer;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    last_beat = (vrf_beat == BEAT_W'(BEATS - 1));
    next_beat = vrf_beat + 1'b1;
    accept    = (state == IDLE) || ((state == BURST) && last_beat);
    grant_alu = alu_valid && (!ld_valid || !prio_ld);
    grant_ld  = ld_valid && (!alu_valid || prio_ld);
    alu_ready = accept && grant_alu;
    ld_ready  = accept && grant_ld;
    xfer      = alu_ready || ld_ready;
    in_data   = grant_alu ? alu_data : ld_data;
    in_vd     = grant_alu ? alu_vd : ld_vd;
  end

  // NOTE: the captured vector is a wide datapath register left unreset; vrf_we qualifies every use of it.
  always_ff @(posedge clk) begin
    if (xfer) cap_data <= in_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio_ld   <= 1'b0;
      vrf_we    <= 1'b0;
      vrf_vd    <= '0;
      vrf_beat  <= '0;
      vrf_wdata <= '0;
      wb_last   <= 1'b0;
      busy      <= 1'b0;
      busy_vd   <= '0;
    end else if (xfer) begin
      // Beat 0 comes straight from the requester so the first write lands one cycle after transfer.
      state     <= BURST;
      prio_ld   <= grant_alu;
      vrf_we    <= 1'b1;
      vrf_vd    <= in_vd;
      vrf_beat  <= '0;
      vrf_wdata <= in_data[0];
      wb_last   <= (BEATS == 1);
      busy      <= 1'b1;
      busy_vd   <= in_vd;
    end else if (state == BURST && !last_beat) begin
      vrf_beat  <= next_beat;
      vrf_wdata <= cap_data[next_beat];
      wb_last   <= (next_beat == BEAT_W'(BEATS - 1));
    end else begin
      state   <= IDLE;
      vrf_we  <= 1'b0;
      wb_last <= 1'b0;
      busy    <= 1'b0;
    end
  end

`ifdef VWB_STALL_CNT_EN
  logic stall;
  assign stall = (alu_valid && !alu_ready) || (ld_valid && !ld_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         stall_cnt <= '0;
    else if (stall && stall_cnt != '1)  stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule
